load_store_unit: RTL and testbench

- Multi-cycle load/store unit between the single-cycle core's data-memory port (MemRead/MemWrite/address/WriteData/funct3) and a word-wide memory bus with request/ready/response handshake.
- Generates byte strobes and lane-replicated store data, and sign/zero-extends loads.
- Raises Stall so the core's PC and register write hold while a bus access is outstanding.
- Flags misaligned or undefined accesses and bus timeouts.

---
 rtl/load_store_unit_if.sv | 31 +++
 rtl/load_store_unit.sv | 199 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Word-wide memory bus between the load/store unit and data memory.
//   mem_req    : LSU -> mem, request valid (held until mem_ready)
//   mem_we     : LSU -> mem, 1 = write
//   mem_addr   : LSU -> mem, word-aligned byte address
//   mem_wstrb  : LSU -> mem, byte enables (zero for loads)
//   mem_wdata  : LSU -> mem, lane-replicated store data
//   mem_ready  : mem -> LSU, request accepted this cycle
//   mem_rvalid : mem -> LSU, read data valid
//   mem_rdata  : mem -> LSU, read data word
interface load_store_unit_if #(
    parameter int Width = 32
);
    logic             mem_req;
    logic             mem_we;
    logic [Width-1:0] mem_addr;
    logic [3:0]       mem_wstrb;
    logic [Width-1:0] mem_wdata;
    logic             mem_ready;
    logic             mem_rvalid;
    logic [Width-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit bridging the single-cycle core's data port to
// a request/ready/response memory bus.
//   clk, LSUrst        : clock, synchronous active-high reset
//   MemRead, MemWrite  : core access request (held by the core while Stall)
//   funct3             : size/sign (lb, lh, lw, lbu, lhu)
//   address, WriteData : byte address and store data from the core
//   ReadData           : extended load result, held until the next load
//   Stall              : core must hold PC/register write (combinational)
//   AlignErr           : misaligned/undefined access, no bus access made
//   BusErr             : bus timeout, pulses in the completion cycle
//   bus                : memory bus (master side)
module load_store_unit #(
    parameter int Width         = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                     clk,
    input  logic                     LSUrst,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    input  logic [2:0]               funct3,
    input  logic [Width-1:0]         address,
    input  logic [Width-1:0]         WriteData,
    output logic [Width-1:0]         ReadData,
    output logic                     Stall,
    output logic                     AlignErr,
    output logic                     BusErr,
    load_store_unit_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Abort on the last allowed cycle of REQ+WAIT_R when nothing completed.
    localparam logic [7:0] CNT_LIMIT = 8'(TimeoutCycles - 1);

    state_t           state_r, state_nxt_s;
    logic [7:0]       cnt_r;
    logic             op_s, legal_s, launch_s, capture_s, timeout_s;
    logic [3:0]       size_strb_s;
    logic [Width-1:0] size_wdata_s, ext_s;
    logic [7:0]       byte_s;
    logic [15:0]      half_s;
    logic             load_r, req_r, we_r, bus_err_r;
    logic [1:0]       lane_r;
    logic [2:0]       f3_r;
    logic [Width-1:0] addr_r, wdata_r, read_data_r;
    logic [3:0]       wstrb_r;

    assign op_s     = MemRead | MemWrite;
    assign launch_s = (state_r == IDLE) & op_s & legal_s;
    assign Stall    = launch_s | (state_r == REQ) | (state_r == WAIT_R);
    assign AlignErr = (state_r == IDLE) & op_s & ~legal_s;

    assign ReadData      = read_data_r;
    assign BusErr        = bus_err_r;
    assign bus.mem_req   = req_r;
    assign bus.mem_we    = we_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wstrb = wstrb_r;
    assign bus.mem_wdata = wdata_r;

    // Legality check plus store strobe/lane replication from the live request.
    always_comb begin
        legal_s      = 1'b0;
        size_strb_s  = 4'b0000;
        size_wdata_s = WriteData;
        case (funct3)
            3'b000, 3'b100: begin
                legal_s      = 1'b1;
                size_strb_s  = 4'b0001 << address[1:0];
                size_wdata_s = {(Width/8){WriteData[7:0]}};
            end
            3'b001, 3'b101: begin
                legal_s      = ~address[0];
                size_strb_s  = address[1] ? 4'b1100 : 4'b0011;
                size_wdata_s = {(Width/16){WriteData[15:0]}};
            end
            3'b010: begin
                legal_s      = (address[1:0] == 2'b00);
                size_strb_s  = 4'b1111;
                size_wdata_s = WriteData;
            end
            default: begin
                legal_s      = 1'b0;
                size_strb_s  = 4'b0000;
                size_wdata_s = WriteData;
            end
        endcase
    end

    // Lane selection and sign/zero extension of the returned word.
    always_comb begin
        byte_s = bus.mem_rdata[{lane_r, 3'b000} +: 8];
        half_s = bus.mem_rdata[{lane_r[1], 4'b0000} +: 16];
        case (f3_r)
            3'b000:  ext_s = {{(Width-8){byte_s[7]}}, byte_s};
            3'b100:  ext_s = {{(Width-8){1'b0}}, byte_s};
            3'b001:  ext_s = {{(Width-16){half_s[15]}}, half_s};
            3'b101:  ext_s = {{(Width-16){1'b0}}, half_s};
            default: ext_s = bus.mem_rdata;
        endcase
    end

    // Next-state logic; also decides when a load result is captured or aborted.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (launch_s) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (bus.mem_ready) begin
                    if (!load_r) begin
                        state_nxt_s = DONE;
                    end else if (bus.mem_rvalid) begin
                        capture_s   = 1'b1;
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = WAIT_R;
                    end
                end else if (cnt_r == CNT_LIMIT) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            WAIT_R: begin
                if (bus.mem_rvalid) begin
                    capture_s   = 1'b1;
                    state_nxt_s = DONE;
                end else if (cnt_r == CNT_LIMIT) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = WAIT_R;
                end
            end
            // The op still presented in DONE is the one just committed.
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, timeout counter, latched request and registered outputs.
    always_ff @(posedge clk) begin
        if (LSUrst) begin
            state_r     <= IDLE;
            cnt_r       <= 8'd0;
            load_r      <= 1'b0;
            lane_r      <= 2'b00;
            f3_r        <= 3'b000;
            req_r       <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= '0;
            wstrb_r     <= 4'b0000;
            wdata_r     <= '0;
            read_data_r <= '0;
            bus_err_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            req_r     <= (state_nxt_s == REQ);
            bus_err_r <= timeout_s;
            if ((state_r == REQ) || (state_r == WAIT_R)) begin
                cnt_r <= cnt_r + 8'd1;
            end else begin
                cnt_r <= 8'd0;
            end
            if (launch_s) begin
                // A simultaneous read and write is treated as a load only.
                load_r  <= MemRead;
                we_r    <= ~MemRead;
                lane_r  <= address[1:0];
                f3_r    <= funct3;
                addr_r  <= {address[Width-1:2], 2'b00};
                wstrb_r <= MemRead ? 4'b0000 : size_strb_s;
                wdata_r <= size_wdata_s;
            end
            if (capture_s) begin
                read_data_r <= ext_s;
            end else if (timeout_s && load_r) begin
                read_data_r <= '0;
            end else begin
                read_data_r <= read_data_r;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        LSUrst, MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] address, WriteData, ReadData;
    logic        Stall, AlignErr, BusErr;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_rd = 32'd0;

    load_store_unit_if #(.Width(32)) bus ();

    load_store_unit #(.Width(32), .TimeoutCycles(TO)) dut (
        .clk(clk), .LSUrst(LSUrst), .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .address(address), .WriteData(WriteData),
        .ReadData(ReadData), .Stall(Stall), .AlignErr(AlignErr),
        .BusErr(BusErr), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Access size in bytes; 0 marks an undefined funct3.
    function automatic int unsigned acc_bytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
        logic [31:0] v;
        v = w >> (8 * (a % 4));
        case (f3)
            3'b000: begin v = v & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
            3'b100: v = v & 32'hFF;
            3'b001: begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
            3'b101: v = v & 32'hFFFF;
            default: v = w;
        endcase
        return v;
    endfunction

    // Idle cycles with junk bus responses that must be ignored.
    task automatic idle(input int n);
        repeat (n) begin
            MemRead = 1'b0; MemWrite = 1'b0;
            bus.mem_ready = 1'($urandom); bus.mem_rvalid = 1'($urandom);
            bus.mem_rdata = $urandom;
            @(negedge clk);
            chk("idle_stall", {31'd0, Stall}, 32'd0);
            chk("idle_req", {31'd0, bus.mem_req}, 32'd0);
            chk("idle_rd", ReadData, exp_rd);
            @(posedge clk); #1;
        end
    endtask

    // One core access; entered and left 1 time unit after a rising edge.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdat, input int ready_dly, input int rvalid_dly);
        int unsigned nb, mask;
        logic is_load, legal, done, to, in_wait;
        logic [31:0] xwd;
        int n, c, d;
        nb = acc_bytes(f3);
        is_load = rd;
        legal = (nb != 0) && ((a % nb) == 0);
        mask = ((1 << nb) - 1) << (a % 4);
        xwd = (nb == 1) ? (wd & 32'hFF) * 32'h01010101 :
              (nb == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
        MemRead = rd; MemWrite = wr; funct3 = f3; address = a; WriteData = wd;
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = rdat;
        @(negedge clk);
        chk("launch_align", {31'd0, AlignErr}, {31'd0, !legal});
        chk("launch_stall", {31'd0, Stall}, {31'd0, legal});
        chk("launch_req", {31'd0, bus.mem_req}, 32'd0);
        @(posedge clk); #1;
        if (!legal) begin
            MemRead = 1'b0; MemWrite = 1'b0;
            return;
        end
        n = 0; c = 0; d = 0; done = 1'b0; to = 1'b0; in_wait = 1'b0;
        while (!done) begin
            n++;
            if (!in_wait) begin
                bus.mem_ready = (c == ready_dly);
                bus.mem_rvalid = is_load ? (bus.mem_ready && rvalid_dly == 0) : 1'($urandom);
                bus.mem_rdata = rdat;
                @(negedge clk);
                chk("req_req", {31'd0, bus.mem_req}, 32'd1);
                chk("req_stall", {31'd0, Stall}, 32'd1);
                chk("req_addr", bus.mem_addr, a & 32'hFFFFFFFC);
                chk("req_we", {31'd0, bus.mem_we}, {31'd0, !is_load});
                chk("req_wstrb", {28'd0, bus.mem_wstrb}, is_load ? 32'd0 : mask);
                if (!is_load) chk("req_wdata", bus.mem_wdata, xwd);
                if (bus.mem_ready) begin
                    if (!is_load || bus.mem_rvalid) done = 1'b1;
                    else in_wait = 1'b1;
                end else if (n == TO) begin
                    done = 1'b1; to = 1'b1;
                end
                c++;
            end else begin
                d++;
                bus.mem_rvalid = (d == rvalid_dly);
                bus.mem_ready = 1'($urandom);
                bus.mem_rdata = bus.mem_rvalid ? rdat : $urandom;
                @(negedge clk);
                chk("wait_req", {31'd0, bus.mem_req}, 32'd0);
                chk("wait_stall", {31'd0, Stall}, 32'd1);
                if (bus.mem_rvalid) done = 1'b1;
                else if (n == TO) begin done = 1'b1; to = 1'b1; end
            end
            @(posedge clk); #1;
        end
        if (is_load) exp_rd = to ? 32'd0 : load_val(f3, a, rdat);
        // DONE: request still presented, stray responses must be ignored.
        bus.mem_ready = 1'($urandom); bus.mem_rvalid = 1'($urandom); bus.mem_rdata = $urandom;
        @(negedge clk);
        chk("done_stall", {31'd0, Stall}, 32'd0);
        chk("done_req", {31'd0, bus.mem_req}, 32'd0);
        chk("done_buserr", {31'd0, BusErr}, {31'd0, to});
        chk("done_rd", ReadData, exp_rd);
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    initial begin
        LSUrst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
        address = 32'd0; WriteData = 32'd0;
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rd", ReadData, 32'd0);
        chk("rst_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        chk("rst_align", {31'd0, AlignErr}, 32'd0);
        chk("rst_buserr", {31'd0, BusErr}, 32'd0);
        chk("rst_stall", {31'd0, Stall}, 32'd0);
        @(posedge clk); #1;
        LSUrst = 1'b0;
        idle(2);

        // Directed cases.
        run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0, 0);
        run_op(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF0000, 0, 3);
        run_op(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF0000, 0, 3);
        run_op(1'b0, 1'b1, 3'b001, 32'h22, 32'h1234ABCD, 32'd0, 4, 0);
        run_op(1'b1, 1'b0, 3'b010, 32'h102, 32'd0, 32'd0, 0, 0);
        run_op(1'b1, 1'b0, 3'b011, 32'h100, 32'd0, 32'd0, 0, 0);
        idle(1);
        run_op(1'b1, 1'b0, 3'b101, 32'h202, 32'd0, 32'h9ABC1234, 1, 1);
        run_op(1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 32'h11111111, 100, 0);
        run_op(1'b0, 1'b1, 3'b000, 32'h201, 32'hA5A5A5C3, 32'd0, 100, 0);
        run_op(1'b1, 1'b1, 3'b001, 32'h302, 32'hFFFFFFFF, 32'h8001FFFF, 2, 2);
        idle(1);

        // Randomised accesses with short bus latencies.
        for (int i = 0; i < 60; i++) begin
            int unsigned sel;
            sel = $urandom_range(2, 0);
            run_op(sel != 32'd1, sel != 32'd0, 3'($urandom_range(7, 0)), $urandom, $urandom,
                   $urandom, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
            if ($urandom_range(1, 0) == 1) idle(1);
        end

        // Reset while waiting for a load response; the late response is dropped.
        run_op(1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 32'hCAFEF00D, 0, 0);
        MemRead = 1'b1; funct3 = 3'b010; address = 32'h44;
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;
        @(posedge clk); #1;
        bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b0;
        @(negedge clk);
        chk("mid_req", {31'd0, bus.mem_req}, 32'd1);
        @(posedge clk); #1;
        bus.mem_ready = 1'b0; LSUrst = 1'b1;
        @(negedge clk);
        chk("mid_wait_stall", {31'd0, Stall}, 32'd1);
        @(posedge clk); #1;
        LSUrst = 1'b0; MemRead = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55;
        exp_rd = 32'd0;
        @(negedge clk);
        chk("mid_rst_stall", {31'd0, Stall}, 32'd0);
        chk("mid_rst_req", {31'd0, bus.mem_req}, 32'd0);
        chk("mid_rst_rd", ReadData, 32'd0);
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        chk("mid_late_rd", ReadData, 32'd0);
        chk("mid_late_stall", {31'd0, Stall}, 32'd0);
        @(posedge clk); #1;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
